// File: rtl/nap_countdown.sv
// Nap countdown timer: captures HH:MM:SS from the setting stage, counts down once per
// second in BCD, then holds a timed alarm before returning to idle.
module nap_countdown #(
  parameter int unsigned CLK_DIV    = 1000,
  parameter int unsigned ALARM_SECS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       completeSetting,
  input  logic [3:0] hour_ten_in,
  input  logic [3:0] hour_one_in,
  input  logic [3:0] min_ten_in,
  input  logic [3:0] min_one_in,
  input  logic [3:0] sec_ten_in,
  input  logic [3:0] sec_one_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] hour_ten_out,
  output logic [3:0] hour_one_out,
  output logic [3:0] min_ten_out,
  output logic [3:0] min_one_out,
  output logic [3:0] sec_ten_out,
  output logic [3:0] sec_one_out,
  output logic       running,
  output logic       alarm,
  output logic       done_pulse
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_SECS - 1);
  // Per-digit borrow targets, packed in the same order as time_q (sec_one in the LSBs).
  localparam logic [23:0] DIGIT_TOP = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUNNING,
    S_PAUSED,
    S_ALARM
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          done_q, done_d;
  logic          cs_q;

  logic          load_ok, counting, tick, at_end;
  logic [23:0]   load_val, dec_val;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] top);
    return (v > top) ? top : v;
  endfunction

  // Returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_dec(input logic [3:0] v, input logic [3:0] top,
                                         input logic b_in);
    if (!b_in)     return {1'b0, v};
    if (v == 4'd0) return {1'b1, top};
    return {1'b0, v - 4'd1};
  endfunction

  assign load_val = {clamp(hour_ten_in, 4'd9), clamp(hour_one_in, 4'd9),
                     clamp(min_ten_in, 4'd5),  clamp(min_one_in, 4'd9),
                     clamp(sec_ten_in, 4'd5),  clamp(sec_one_in, 4'd9)};
  assign load_ok  = completeSetting && !cs_q && (state_q inside {S_IDLE, S_LOADED, S_PAUSED});
  assign counting = state_q inside {S_RUNNING, S_ALARM};
  assign tick     = counting && (presc_q == PRESC_MAX);
  assign at_end   = (time_q == 24'h000001) || (time_q == '0);

  always_comb begin : dec_chain
    logic [4:0] r;
    logic       b;
    dec_val = time_q;
    b       = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      r                 = bcd_dec(time_q[i*4 +: 4], DIGIT_TOP[i*4 +: 4], b);
      dec_val[i*4 +: 4] = r[3:0];
      b                 = r[4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      presc_q <= '0;
      acnt_q  <= '0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      cs_q    <= completeSetting;
    end
  end

  // Event priority: clear > load > start_stop > tick.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (load_ok) begin
      state_d = (load_val == '0) ? S_IDLE : S_LOADED;
    end else if (start_stop) begin
      case (state_q)
        S_LOADED:  state_d = S_RUNNING;
        S_RUNNING: state_d = S_PAUSED;
        S_PAUSED:  state_d = S_RUNNING;
        S_ALARM:   state_d = S_IDLE;
        default:   state_d = state_q;
      endcase
    end else if (tick) begin
      if (state_q == S_RUNNING && at_end)                 state_d = S_ALARM;
      else if (state_q == S_ALARM && acnt_q == ACNT_LAST) state_d = S_IDLE;
    end
  end

  // A pause holds presc_q so resuming keeps the partial second.
  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
    if (clear) begin
      time_d  = '0;
      presc_d = '0;
      acnt_d  = '0;
    end else if (load_ok) begin
      time_d  = load_val;
      presc_d = '0;
      acnt_d  = '0;
    end else if (start_stop) begin
      if (state_q == S_LOADED) presc_d = '0;
      if (state_q == S_ALARM) begin
        presc_d = '0;
        acnt_d  = '0;
      end
    end else if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && state_q == S_RUNNING) begin
        if (at_end) begin
          time_d = '0;
          acnt_d = '0;
          done_d = 1'b1;
        end else begin
          time_d = dec_val;
        end
      end else if (tick && state_q == S_ALARM) begin
        acnt_d = (acnt_q == ACNT_LAST) ? '0 : acnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    running = (state_q == S_RUNNING);
    alarm   = (state_q == S_ALARM);
  end

  assign done_pulse   = done_q;
  assign hour_ten_out = time_q[23:20];
  assign hour_one_out = time_q[19:16];
  assign min_ten_out  = time_q[15:12];
  assign min_one_out  = time_q[11:8];
  assign sec_ten_out  = time_q[7:4];
  assign sec_one_out  = time_q[3:0];

endmodule

// File: tb/tb_nap_countdown.sv
// Bench for nap_countdown: directed scenarios plus randomized traffic against a
// seconds-based reference model.
module tb_nap_countdown;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned ALARM_SECS = 3;
  localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSED = 3, M_ALARM = 4;

  logic       clk = 1'b0;
  logic       rst, completeSetting, start_stop, clear;
  logic [3:0] hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in;
  logic [3:0] hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out;
  logic       running, alarm, done_pulse;
  logic [23:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  int   m_mode, m_secs, m_phase, m_acnt;
  logic m_prev_cs, m_done;

  always #5 clk = ~clk;

  nap_countdown #(.CLK_DIV(CLK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst(rst), .completeSetting(completeSetting),
    .hour_ten_in(hour_ten_in), .hour_one_in(hour_one_in),
    .min_ten_in(min_ten_in), .min_one_in(min_one_in),
    .sec_ten_in(sec_ten_in), .sec_one_in(sec_one_in),
    .start_stop(start_stop), .clear(clear),
    .hour_ten_out(hour_ten_out), .hour_one_out(hour_one_out),
    .min_ten_out(min_ten_out), .min_one_out(min_one_out),
    .sec_ten_out(sec_ten_out), .sec_one_out(sec_one_out),
    .running(running), .alarm(alarm), .done_pulse(done_pulse)
  );

  assign obs = {hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out};

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int cl(input logic [3:0] v, input int top);
    return (int'(v) > top) ? top : int'(v);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_acnt = 0; m_prev_cs = 1'b0; m_done = 1'b0;
  endtask

  // One clock of the timer described in whole seconds rather than digits.
  task automatic model_step();
    logic ld;
    if (rst) begin
      model_reset();
      return;
    end
    ld = completeSetting && !m_prev_cs;
    m_prev_cs = completeSetting;
    m_done = 1'b0;
    if (clear) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_acnt = 0;
    end else if (ld && (m_mode == M_IDLE || m_mode == M_LOADED || m_mode == M_PAUSED)) begin
      m_secs = (cl(hour_ten_in, 9) * 10 + cl(hour_one_in, 9)) * 3600
             + (cl(min_ten_in, 5) * 10 + cl(min_one_in, 9)) * 60
             + cl(sec_ten_in, 5) * 10 + cl(sec_one_in, 9);
      m_mode = (m_secs != 0) ? M_LOADED : M_IDLE;
      m_phase = 0; m_acnt = 0;
    end else if (start_stop && m_mode != M_IDLE) begin
      case (m_mode)
        M_LOADED: begin m_mode = M_RUN; m_phase = 0; end
        M_RUN:    m_mode = M_PAUSED;
        M_PAUSED: m_mode = M_RUN;
        default:  begin m_mode = M_IDLE; m_phase = 0; m_acnt = 0; end
      endcase
    end else if (m_mode == M_RUN || m_mode == M_ALARM) begin
      if (m_phase == int'(CLK_DIV) - 1) begin
        m_phase = 0;
        if (m_mode == M_RUN) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_mode = M_ALARM; m_acnt = 0; m_done = 1'b1; end
        end else begin
          m_acnt = m_acnt + 1;
          if (m_acnt == int'(ALARM_SECS)) begin m_mode = M_IDLE; m_acnt = 0; end
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] a, b, c, d, e, f);
    hour_ten_in = a; hour_one_in = b; min_ten_in = c; min_one_in = d; sec_ten_in = e; sec_one_in = f;
    completeSetting = 1'b1;
    cyc();
    completeSetting = 1'b0;
    cyc();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    n_cmp++;
    if (obs !== 24'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 000000", obs); end
    n_cmp++;
    if ({running, alarm, done_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {running, alarm, done_pulse});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_countdown();
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3);
    n_cmp++;
    if (obs !== 24'h000003 || running !== 1'b0) begin
      n_fail++; $display("FAIL load_003: got %h run=%b want 000003 run=0", obs, running);
    end
    pulse_ss();
    n_cmp++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_run: got %b want 1", running); end
    repeat (3) cyc();
    n_cmp++;
    if (obs !== 24'h000003) begin n_fail++; $display("FAIL pre_tick: got %h want 000003", obs); end
    cyc();
    n_cmp++;
    if (obs !== 24'h000002) begin n_fail++; $display("FAIL first_dec: got %h want 000002", obs); end
    repeat (4) cyc();
    n_cmp++;
    if (obs !== 24'h000001) begin n_fail++; $display("FAIL second_dec: got %h want 000001", obs); end
    repeat (3) cyc();
    n_cmp++;
    if (obs !== 24'h000001 || done_pulse !== 1'b0) begin
      n_fail++; $display("FAIL hold_01: got %h done=%b want 000001 done=0", obs, done_pulse);
    end
    cyc();
    n_cmp++;
    if (obs !== 24'h0 || done_pulse !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got %h done=%b alarm=%b run=%b want 000000 1 1 0",
                         obs, done_pulse, alarm, running);
    end
    cyc();
    n_cmp++;
    if (done_pulse !== 1'b0 || alarm !== 1'b1) begin
      n_fail++; $display("FAIL done_one_cycle: got done=%b alarm=%b want 0 1", done_pulse, alarm);
    end
  endtask

  task automatic test_alarm_timeout();
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_hold[%0d]: got %b want 1", i, alarm); end
    end
    cyc();
    n_cmp++;
    if (alarm !== 1'b0 || running !== 1'b0 || obs !== 24'h0) begin
      n_fail++; $display("FAIL alarm_timeout: got alarm=%b run=%b %h want 0 0 000000", alarm, running, obs);
    end
  endtask

  task automatic test_alarm_stop();
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1);
    pulse_ss();
    repeat (4) cyc();
    n_cmp++;
    if (alarm !== 1'b1 || done_pulse !== 1'b1) begin
      n_fail++; $display("FAIL alarm_enter: got alarm=%b done=%b want 1 1", alarm, done_pulse);
    end
    repeat (3) cyc();
    pulse_ss();
    n_cmp++;
    if (alarm !== 1'b0 || obs !== 24'h0) begin
      n_fail++; $display("FAIL alarm_stop: got alarm=%b %h want 0 000000", alarm, obs);
    end
  endtask

  task automatic test_borrow();
    do_load(4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
    pulse_ss();
    repeat (4) cyc();
    n_cmp++;
    if (obs !== 24'h005959) begin n_fail++; $display("FAIL borrow_1h: got %h want 005959", obs); end
    pulse_clear();
    do_load(4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    pulse_ss();
    repeat (4) cyc();
    n_cmp++;
    if (obs !== 24'h095959) begin n_fail++; $display("FAIL borrow_10h: got %h want 095959", obs); end
    pulse_clear();
  endtask

  task automatic test_clamp();
    do_load(4'd2, 4'd3, 4'd7, 4'd12, 4'd9, 4'd15);
    n_cmp++;
    if (obs !== 24'h235959 || running !== 1'b0) begin
      n_fail++; $display("FAIL clamp: got %h run=%b want 235959 run=0", obs, running);
    end
    pulse_clear();
  endtask

  task automatic test_pause();
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
    pulse_ss();
    repeat (2) cyc();
    pulse_ss();
    n_cmp++;
    if (running !== 1'b0 || obs !== 24'h000010) begin
      n_fail++; $display("FAIL pause_enter: got run=%b %h want 0 000010", running, obs);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_cmp++;
      if (obs !== 24'h000010) begin n_fail++; $display("FAIL pause_hold[%0d]: got %h want 000010", i, obs); end
    end
    pulse_ss();
    n_cmp++;
    if (running !== 1'b1 || obs !== 24'h000010) begin
      n_fail++; $display("FAIL resume: got run=%b %h want 1 000010", running, obs);
    end
    cyc();
    n_cmp++;
    if (obs !== 24'h000010) begin n_fail++; $display("FAIL resume_hold: got %h want 000010", obs); end
    cyc();
    n_cmp++;
    if (obs !== 24'h000009) begin n_fail++; $display("FAIL resume_dec: got %h want 000009", obs); end
  endtask

  task automatic test_async_reset();
    pulse_clear();
    do_load(4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0);
    pulse_ss();
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 24'h0 || {running, alarm, done_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset: got %h flags=%b want 000000 000", obs, {running, alarm, done_pulse});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_clear_load();
    do_load(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    hour_ten_in = 4'd0; hour_one_in = 4'd0; min_ten_in = 4'd0;
    min_one_in = 4'd0; sec_ten_in = 4'd4; sec_one_in = 4'd5;
    clear = 1'b1; completeSetting = 1'b1;
    cyc();
    clear = 1'b0; completeSetting = 1'b0;
    n_cmp++;
    if (obs !== 24'h0 || running !== 1'b0) begin
      n_fail++; $display("FAIL clear_over_load: got %h run=%b want 000000 0", obs, running);
    end
    pulse_ss();
    n_cmp++;
    if (running !== 1'b0 || obs !== 24'h0) begin
      n_fail++; $display("FAIL ss_in_idle: got run=%b %h want 0 000000", running, obs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      clear      = ($urandom_range(299) == 0);
      start_stop = ($urandom_range(39) == 0);
      if ($urandom_range(7) == 0) completeSetting = ~completeSetting;
      if ($urandom_range(3) != 0) begin
        hour_ten_in = 4'd0; hour_one_in = 4'd0; min_ten_in = 4'd0; min_one_in = 4'd0;
        sec_ten_in = 4'($urandom_range(1)); sec_one_in = 4'($urandom_range(15));
      end else begin
        hour_ten_in = 4'($urandom_range(15)); hour_one_in = 4'($urandom_range(15));
        min_ten_in  = 4'($urandom_range(15)); min_one_in  = 4'($urandom_range(15));
        sec_ten_in  = 4'($urandom_range(15)); sec_one_in  = 4'($urandom_range(15));
      end
      cyc();
      n_cmp++;
      if (obs !== to_bcd(m_secs)) begin
        n_fail++; $display("FAIL rnd_digits[%0d]: got %h want %h", i, obs, to_bcd(m_secs));
      end
      n_cmp++;
      if (running !== (m_mode == M_RUN) || alarm !== (m_mode == M_ALARM)) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got run=%b alarm=%b want mode %0d", i, running, alarm, m_mode);
      end
      n_cmp++;
      if (done_pulse !== m_done) begin
        n_fail++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done_pulse, m_done);
      end
    end
    clear = 1'b0; start_stop = 1'b0; completeSetting = 1'b0;
  endtask

  initial begin
    rst = 1'b1; completeSetting = 1'b0; start_stop = 1'b0; clear = 1'b0;
    hour_ten_in = 4'd0; hour_one_in = 4'd0; min_ten_in = 4'd0;
    min_one_in = 4'd0; sec_ten_in = 4'd0; sec_one_in = 4'd0;
    model_reset();
    test_reset();
    test_countdown();
    test_alarm_timeout();
    test_alarm_stop();
    test_borrow();
    test_clamp();
    test_pause();
    test_async_reset();
    test_clear_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
